pipe_hazard_ctrl: RTL and testbench

- Central stall/flush/forwarding controller for the 5-stage 8-bit pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC enable.
- Detects load-use hazards and taken branches, selects ALU operand forwarding, and sequences the data-memory request/acknowledge handshake, freezing the pipe while memory is busy.
- Keeps a saturating count of stall cycles for performance measurement.

---
 rtl/pipe_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control for the 5-stage pipeline, with data-memory wait and stall-cycle counting.
module pipe_hazard_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int STALL_CNT_W      = 16,
    parameter int R0_ZERO          = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             IDr1Addr,
    input  logic [2:0]             IDr2Addr,
    input  logic                   IDuseR1,
    input  logic                   IDuseR2,
    input  logic [2:0]             EXr1Addr,
    input  logic [2:0]             EXr2Addr,
    input  logic [2:0]             EXdest,
    input  logic                   EXregWrite,
    input  logic                   EXregWriteDataSel,
    input  logic [2:0]             MEMdest,
    input  logic                   MEMregWrite,
    input  logic                   MEMregWriteDataSel,
    input  logic                   MEMDMMemWrite,
    input  logic [2:0]             WBdest,
    input  logic                   WBregWrite,
    input  logic                   branchTaken,
    input  logic                   dmAck,
    output logic                   pcEnb,
    output logic                   IFIDenb,
    output logic                   IDEXenb,
    output logic                   EXMEMenb,
    output logic                   MEMWBenb,
    output logic                   IFIDflush,
    output logic                   IDEXflush,
    output logic [1:0]             fwdA,
    output logic [1:0]             fwdB,
    output logic                   dmReq,
    output logic [STALL_CNT_W-1:0] stallCount
);
    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    localparam logic [1:0] BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

    state_t                 state_q, state_d;
    logic [1:0]             bub_q, bub_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   mem_op, lu_haz, freeze, lu_stall;
    logic                   mem_a, mem_b, wb_a, wb_b;

    function automatic logic match(input logic [2:0] a, input logic [2:0] b);
        return (a == b) && (R0_ZERO == 0 || b != 3'd0);
    endfunction

    assign mem_op = MEMDMMemWrite | (MEMregWrite & MEMregWriteDataSel);
    assign lu_haz = EXregWrite & EXregWriteDataSel &
                    ((IDuseR1 & match(IDr1Addr, EXdest)) | (IDuseR2 & match(IDr2Addr, EXdest)));
    assign mem_a  = MEMregWrite & ~MEMregWriteDataSel & match(EXr1Addr, MEMdest);
    assign mem_b  = MEMregWrite & ~MEMregWriteDataSel & match(EXr2Addr, MEMdest);
    assign wb_a   = WBregWrite & match(EXr1Addr, WBdest);
    assign wb_b   = WBregWrite & match(EXr2Addr, WBdest);

    // A nonzero bubble counter means a load-use stall is still owed, even right after a memory wait.
    always_comb begin
        dmReq     = rst & (state_q == MEM_WAIT || mem_op);
        freeze    = dmReq & ~dmAck;
        lu_stall  = rst & ~freeze & ~branchTaken & (bub_q != 2'd0 || lu_haz);
        pcEnb     = ~(freeze | lu_stall);
        IFIDenb   = ~(freeze | lu_stall);
        IDEXenb   = ~freeze;
        EXMEMenb  = ~freeze;
        MEMWBenb  = ~freeze;
        IFIDflush = rst & ~freeze & branchTaken;
        IDEXflush = (rst & ~freeze & branchTaken) | lu_stall;
        fwdA      = ~rst ? 2'b00 : mem_a ? 2'b10 : wb_a ? 2'b01 : 2'b00;
        fwdB      = ~rst ? 2'b00 : mem_b ? 2'b10 : wb_b ? 2'b01 : 2'b00;
    end

    always_comb begin
        bub_d       = freeze ? bub_q :
                      branchTaken ? 2'd0 :
                      bub_q != 2'd0 ? (state_q == MEM_WAIT ? bub_q : bub_q - 2'd1) :
                      lu_haz ? BUB_INIT : 2'd0;
        state_d     = freeze ? MEM_WAIT : bub_d != 2'd0 ? LU_STALL : RUN;
        stall_cnt_d = (!pcEnb && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            bub_q       <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bub_q       <= bub_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench comparing two parameterisations of pipe_hazard_ctrl against a pending-bubble model.
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        bit [2:0] id1, id2, ex1, ex2, exd, memd, wbd;
        bit useR1, useR2, exW, exL, memW, memL, memS, wbW, br, ack, rst;
    } in_t;
    typedef struct packed {
        bit pc, ifid, idex, exmem, memwb, f1, f2, req;
        bit [1:0] fa, fb;
        int sc;
    } out_t;
    typedef struct packed {
        int pend;
        bit wt;
        int sc;
    } st_t;

    logic clk = 0;
    logic rst;
    logic [2:0] IDr1Addr, IDr2Addr, EXr1Addr, EXr2Addr, EXdest, MEMdest, WBdest;
    logic IDuseR1, IDuseR2, EXregWrite, EXregWriteDataSel, MEMregWrite, MEMregWriteDataSel;
    logic MEMDMMemWrite, WBregWrite, branchTaken, dmAck;
    logic pc0, ifid0, idex0, exmem0, memwb0, iff0, idf0, req0;
    logic pc1, ifid1, idex1, exmem1, memwb1, iff1, idf1, req1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic [15:0] sc0;
    logic [1:0] sc1;

    int n_chk = 0, n_fail = 0, cyc_n = 0;
    out_t q0[$], q1[$];
    st_t st0, st1, nx0, nx1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u0 (
        .clk(clk), .rst(rst), .IDr1Addr(IDr1Addr), .IDr2Addr(IDr2Addr), .IDuseR1(IDuseR1), .IDuseR2(IDuseR2),
        .EXr1Addr(EXr1Addr), .EXr2Addr(EXr2Addr), .EXdest(EXdest), .EXregWrite(EXregWrite),
        .EXregWriteDataSel(EXregWriteDataSel), .MEMdest(MEMdest), .MEMregWrite(MEMregWrite),
        .MEMregWriteDataSel(MEMregWriteDataSel), .MEMDMMemWrite(MEMDMMemWrite), .WBdest(WBdest),
        .WBregWrite(WBregWrite), .branchTaken(branchTaken), .dmAck(dmAck), .pcEnb(pc0), .IFIDenb(ifid0),
        .IDEXenb(idex0), .EXMEMenb(exmem0), .MEMWBenb(memwb0), .IFIDflush(iff0), .IDEXflush(idf0),
        .fwdA(fa0), .fwdB(fb0), .dmReq(req0), .stallCount(sc0));

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .STALL_CNT_W(2), .R0_ZERO(0)) u1 (
        .clk(clk), .rst(rst), .IDr1Addr(IDr1Addr), .IDr2Addr(IDr2Addr), .IDuseR1(IDuseR1), .IDuseR2(IDuseR2),
        .EXr1Addr(EXr1Addr), .EXr2Addr(EXr2Addr), .EXdest(EXdest), .EXregWrite(EXregWrite),
        .EXregWriteDataSel(EXregWriteDataSel), .MEMdest(MEMdest), .MEMregWrite(MEMregWrite),
        .MEMregWriteDataSel(MEMregWriteDataSel), .MEMDMMemWrite(MEMDMMemWrite), .WBdest(WBdest),
        .WBregWrite(WBregWrite), .branchTaken(branchTaken), .dmAck(dmAck), .pcEnb(pc1), .IFIDenb(ifid1),
        .IDEXenb(idex1), .EXMEMenb(exmem1), .MEMWBenb(memwb1), .IFIDflush(iff1), .IDEXflush(idf1),
        .fwdA(fa1), .fwdB(fb1), .dmReq(req1), .stallCount(sc1));

    function automatic bit m(input bit [2:0] a, input bit [2:0] b, input bit r0z);
        return a == b && (!r0z || b != 0);
    endfunction

    function automatic bit [1:0] fw(input bit [2:0] a, input in_t i, input bit r0z);
        if (i.memW && !i.memL && m(a, i.memd, r0z)) return 2'b10;
        if (i.wbW && m(a, i.wbd, r0z)) return 2'b01;
        return 2'b00;
    endfunction

    // Model state: outstanding extra bubbles, whether memory is being waited on, and the stall count (-1 = unknown).
    function automatic void step(input in_t i, input int lub, input bit r0z, input int w, input st_t s,
                                 output out_t o, output st_t n);
        bit lu, frz;
        int maxc;
        n = s;
        o = '0;
        o.sc = s.sc;
        {o.pc, o.ifid, o.idex, o.exmem, o.memwb} = '1;
        if (!i.rst) begin
            n.pend = 0; n.wt = 0; n.sc = 0;
            return;
        end
        o.req = s.wt || i.memS || (i.memW && i.memL);
        frz = o.req && !i.ack;
        lu = i.exW && i.exL && ((i.useR1 && m(i.id1, i.exd, r0z)) || (i.useR2 && m(i.id2, i.exd, r0z)));
        o.fa = fw(i.ex1, i, r0z);
        o.fb = fw(i.ex2, i, r0z);
        if (frz) begin
            {o.pc, o.ifid, o.idex, o.exmem, o.memwb} = '0;
            n.wt = 1;
        end else begin
            n.wt = 0;
            if (i.br) begin
                o.f1 = 1; o.f2 = 1; n.pend = 0;
            end else if (s.pend > 0 || lu) begin
                o.pc = 0; o.ifid = 0; o.f2 = 1;
                n.pend = s.pend > 0 ? (s.wt ? s.pend : s.pend - 1) : lub - 1;
            end
        end
        maxc = (1 << w) - 1;
        if (!o.pc && s.sc >= 0) n.sc = s.sc < maxc ? s.sc + 1 : maxc;
    endfunction

    function automatic in_t idle();
        in_t v = '0;
        v.rst = 1;
        v.ack = 1;
        return v;
    endfunction

    function automatic in_t rnd();
        in_t v;
        v.id1 = 3'($urandom_range(0, 3)); v.id2 = 3'($urandom_range(0, 3));
        v.ex1 = 3'($urandom_range(0, 3)); v.ex2 = 3'($urandom_range(0, 3));
        v.exd = 3'($urandom_range(0, 3)); v.memd = 3'($urandom_range(0, 3));
        v.wbd = 3'($urandom_range(0, 3));
        v.useR1 = 1'($urandom_range(0, 1)); v.useR2 = 1'($urandom_range(0, 1));
        v.exW = 1'($urandom_range(0, 1)); v.exL = 1'($urandom_range(0, 1));
        v.memW = 1'($urandom_range(0, 1)); v.memL = ($urandom_range(0, 3) == 0);
        v.memS = ($urandom_range(0, 5) == 0); v.wbW = 1'($urandom_range(0, 1));
        v.br = ($urandom_range(0, 7) == 0); v.ack = 1'($urandom_range(0, 1));
        v.rst = ($urandom_range(0, 39) != 0);
        return v;
    endfunction

    task automatic apply(input in_t v);
        IDr1Addr = v.id1; IDr2Addr = v.id2; EXr1Addr = v.ex1; EXr2Addr = v.ex2;
        EXdest = v.exd; MEMdest = v.memd; WBdest = v.wbd;
        IDuseR1 = v.useR1; IDuseR2 = v.useR2; EXregWrite = v.exW; EXregWriteDataSel = v.exL;
        MEMregWrite = v.memW; MEMregWriteDataSel = v.memL; MEMDMMemWrite = v.memS;
        WBregWrite = v.wbW; branchTaken = v.br; dmAck = v.ack; rst = v.rst;
    endtask

    task automatic cyc(input in_t v);
        out_t o0, o1;
        @(posedge clk);
        st0 = nx0;
        st1 = nx1;
        #1;
        apply(v);
        step(v, 1, 1, 16, st0, o0, nx0);
        step(v, 3, 0, 2, st1, o1, nx1);
        q0.push_back(o0);
        q1.push_back(o1);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        out_t e;
        cyc_n++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("u0_ctrl", int'({pc0, ifid0, idex0, exmem0, memwb0, iff0, idf0, req0, fa0, fb0}),
                int'({e.pc, e.ifid, e.idex, e.exmem, e.memwb, e.f1, e.f2, e.req, e.fa, e.fb}));
            if (e.sc >= 0) chk("u0_stallCount", int'(sc0), e.sc);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("u1_ctrl", int'({pc1, ifid1, idex1, exmem1, memwb1, iff1, idf1, req1, fa1, fb1}),
                int'({e.pc, e.ifid, e.idex, e.exmem, e.memwb, e.f1, e.f2, e.req, e.fa, e.fb}));
            if (e.sc >= 0) chk("u1_stallCount", int'(sc1), e.sc);
        end
    end

    initial begin
        in_t v;
        nx0 = '{pend: 0, wt: 0, sc: -1};
        nx1 = '{pend: 0, wt: 0, sc: -1};
        v = idle(); v.rst = 0;
        apply(v);
        v.br = 1; v.memS = 1; v.ack = 0;
        repeat (2) cyc(v);
        v = idle(); v.exW = 1; v.exL = 1; v.exd = 3; v.id1 = 3; v.useR1 = 1;
        cyc(v);
        v = idle(); v.wbW = 1; v.wbd = 3; v.ex1 = 3;
        cyc(v);
        v = idle(); v.ex2 = 5; v.memd = 5; v.memW = 1; v.wbd = 5; v.wbW = 1;
        cyc(v);
        v.memW = 0; cyc(v);
        v.ex2 = 0; v.memd = 0; v.wbd = 0; v.memW = 1; cyc(v);
        v = idle(); v.memS = 1; v.ack = 0;
        repeat (3) cyc(v);
        v.ack = 1; cyc(v);
        v = idle(); v.br = 1; v.exW = 1; v.exL = 1; v.exd = 2; v.id2 = 2; v.useR2 = 1;
        cyc(v);
        v.memS = 1; v.ack = 0; repeat (2) cyc(v);
        v.ack = 1; cyc(v);
        v = idle(); v.memS = 1; v.ack = 0; repeat (2) cyc(v);
        v.rst = 0; cyc(v);
        v = idle(); cyc(v);
        repeat (3000) cyc(rnd());
        repeat (2) @(negedge clk);
        chk("queue_drained", q0.size() + q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
